// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU definitions used by the fetch stage and its sub-modules:
//   CPU_PC_W      - default PC / instruction-address width
//   CPU_INSTR_W   - default instruction width
//   CPU_RESET_PC  - default PC value loaded on reset
//   NOP_INSTR     - bubble encoding (all zeros) placed in IF/ID on a flush
//   pc_increment  - sequential next-PC helper (wraps modulo 2^width)
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int unsigned CPU_PC_W     = 7;
    localparam int unsigned CPU_INSTR_W  = 16;
    localparam int unsigned CPU_RESET_PC = 0;

    localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = 16'h0000;

    // Sequential successor of a PC; the carry out is dropped so the address
    // space wraps from all-ones back to zero.
    function automatic logic [CPU_PC_W-1:0] pc_increment(input logic [CPU_PC_W-1:0] pc);
        return pc + {{(CPU_PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program-counter register with asynchronous active-high reset and load enable.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, forces q to RESET_VAL at once
//   en   - load enable (fetch stage drives !StallF)
//   d    - next PC value
//   q    - current PC, driven only by the flop
// -----------------------------------------------------------------------------
module pc_register #(
    parameter int unsigned     W         = 7,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // PC state: reset dominates, otherwise load only when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage of a 5-stage pipeline: PC register, next-PC select
// and the IF/ID pipeline register.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   PCSrcD     - branch taken (resolved in Decode)
//   PCBranchD  - branch target (unsigned address)
//   StallF     - hold the PC register
//   StallD     - hold the IF/ID register (wins over FlushD)
//   FlushD     - load a bubble into IF/ID
//   InstrF     - instruction memory read data for PCF (combinational memory)
//   PCF        - current fetch address (registered)
//   InstrD     - instruction handed to Decode (registered)
//   PC_Plus1D  - PCF+1 handed to Decode (registered)
//   ValidD     - IF/ID holds a real instruction; 0 marks a bubble
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned        PC_W     = CPU_PC_W,
    parameter int unsigned        INSTR_W  = CPU_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = PC_W'(CPU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCSrcD,
    input  logic [PC_W-1:0]    PCBranchD,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [PC_W-1:0]    PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PC_Plus1D,
    output logic               ValidD
);

    logic [PC_W-1:0]    pc_f_s;
    logic [PC_W-1:0]    pc_plus1_f_s;
    logic [PC_W-1:0]    pc_next_f_s;
    logic [INSTR_W-1:0] instr_d_r;
    logic [PC_W-1:0]    pc_plus1_d_r;
    logic               valid_d_r;

    // Sequential successor wraps modulo 2^PC_W; branch target is used as-is.
    always_comb begin
        pc_plus1_f_s = pc_f_s + {{(PC_W-1){1'b0}}, 1'b1};
        if (PCSrcD) begin
            pc_next_f_s = PCBranchD;
        end else begin
            pc_next_f_s = pc_plus1_f_s;
        end
    end

    pc_register #(
        .W         (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_register (
        .clk (clk),
        .rst (rst),
        .en  (!StallF),
        .d   (pc_next_f_s),
        .q   (pc_f_s)
    );

    // IF/ID register: a stall freezes all fields even if a flush is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d_r    <= INSTR_W'(NOP_INSTR);
            pc_plus1_d_r <= {PC_W{1'b0}};
            valid_d_r    <= 1'b0;
        end else if (!StallD) begin
            if (FlushD) begin
                instr_d_r    <= INSTR_W'(NOP_INSTR);
                pc_plus1_d_r <= {PC_W{1'b0}};
                valid_d_r    <= 1'b0;
            end else begin
                instr_d_r    <= InstrF;
                pc_plus1_d_r <= pc_plus1_f_s;
                valid_d_r    <= 1'b1;
            end
        end else begin
            instr_d_r    <= instr_d_r;
            pc_plus1_d_r <= pc_plus1_d_r;
            valid_d_r    <= valid_d_r;
        end
    end

    assign PCF       = pc_f_s;
    assign InstrD    = instr_d_r;
    assign PC_Plus1D = pc_plus1_d_r;
    assign ValidD    = valid_d_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage with a small instruction-memory
// model (imem) and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        PCSrcD;
    logic [6:0]  PCBranchD;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [15:0] InstrF;
    logic [6:0]  PCF;
    logic [15:0] InstrD;
    logic [6:0]  PC_Plus1D;
    logic        ValidD;

    int checks;
    int errors;

    typedef struct {
        logic        sf;
        logic        sd;
        logic        fd;
        logic        ps;
        logic [6:0]  br;
        logic [6:0]  e_pcf;
        logic [15:0] e_instr;
        logic [6:0]  e_pc1;
        logic        e_valid;
    } vec_t;

    vec_t vecs[15];

    // Instruction memory contents: a recognisable tag plus the address.
    function automatic logic [15:0] imem(input logic [6:0] pc);
        return 16'hA500 | {9'b0, pc};
    endfunction

    assign InstrF = imem(PCF);

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PC_Plus1D (PC_Plus1D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] e_pcf, input logic [15:0] e_instr,
                             input logic [6:0] e_pc1, input logic e_valid);
        check({tag, ".PCF"},       {25'b0, PCF},       {25'b0, e_pcf});
        check({tag, ".InstrD"},    {16'b0, InstrD},    {16'b0, e_instr});
        check({tag, ".PC_Plus1D"}, {25'b0, PC_Plus1D}, {25'b0, e_pc1});
        check({tag, ".ValidD"},    {31'b0, ValidD},    {31'b0, e_valid});
    endtask

    // Drive controls, take one rising edge, leave the sample point 1ns after it.
    task automatic apply(input logic sf, input logic sd, input logic fd, input logic ps, input logic [6:0] br);
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        PCSrcD    = ps;
        PCBranchD = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        PCSrcD    = 1'b0;
        PCBranchD = 7'h00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;

        //            sf    sd    fd    ps    br      pcf     instr         pc1     valid
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h01, imem(7'h00), 7'h01, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h02, imem(7'h01), 7'h02, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'h10, 7'h10, 16'h0000,    7'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h11, imem(7'h10), 7'h11, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 7'h11, imem(7'h11), 7'h12, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 7'h11, imem(7'h11), 7'h12, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'h40, 7'h11, imem(7'h11), 7'h12, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 7'h12, imem(7'h11), 7'h12, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 7'h12, 16'h0000,    7'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'h00, 7'h12, 16'h0000,    7'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h13, imem(7'h12), 7'h13, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'h7E, 7'h7E, 16'h0000,    7'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h7F, imem(7'h7E), 7'h7F, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, imem(7'h7F), 7'h00, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 7'h01, imem(7'h00), 7'h01, 1'b1};

        // Reset state before any clock edge.
        #2;
        check_all("reset0", 7'h00, 16'h0000, 7'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("first_edge", 7'h01, imem(7'h00), 7'h01, 1'b1);

        // Re-enter reset to start the table from a known state.
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].br);
            check_all($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_instr, vecs[i].e_pc1, vecs[i].e_valid);
        end

        // Reset mid-run at PCF=0x23 with a branch and stalls pending.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 7'h22);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        check_all("pre_rst", 7'h23, imem(7'h22), 7'h23, 1'b1);
        PCSrcD    = 1'b1;
        PCBranchD = 7'h55;
        StallF    = 1'b1;
        StallD    = 1'b1;
        FlushD    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 7'h00, 16'h0000, 7'h00, 1'b0);
        @(posedge clk);
        #1;
        check_all("held_rst", 7'h00, 16'h0000, 7'h00, 1'b0);
        PCSrcD = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rel_pc0", {25'b0, PCF}, 32'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        check("rel_pc1", {25'b0, PCF}, 32'd1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        check("rel_pc2", {25'b0, PCF}, 32'd2);

        // Branch 0x10 -> 0x05 with flush, then the target's instruction appears.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 7'h10);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 7'h05);
        check_all("br_bubble", 7'h05, 16'h0000, 7'h00, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        check_all("br_target", 7'h06, imem(7'h05), 7'h06, 1'b1);

        // Full stall for three cycles at PCF=0x08, then release.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 7'h07);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        check_all("stall_pre", 7'h08, imem(7'h07), 7'h08, 1'b1);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 7'h00);
            check_all($sformatf("stall%0d", k), 7'h08, imem(7'h07), 7'h08, 1'b1);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        check_all("stall_rel", 7'h09, imem(7'h08), 7'h09, 1'b1);

        // Asymmetric stall at PCF=0x0C: Decode sees the same instruction twice.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 7'h0C);
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
            check_all($sformatf("asym%0d", k), 7'h0C, imem(7'h0C), 7'h0D, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 7, PC/instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PCSrcD  input  1  branch taken, resolved in Decode.
REQ-007 SHALL have port PCBranchD  input  PC_W  branch target from Decode adder.
REQ-008 SHALL have port StallF  input  1  hold PC register.
REQ-009 SHALL have port StallD  input  1  hold IF/ID register.
REQ-010 SHALL have port FlushD  input  1  clear IF/ID register to a bubble.
REQ-011 SHALL have port InstrF  input  INSTR_W  instruction-memory read data for PCF, combinational.
REQ-012 SHALL have port PCF  output  PC_W  current fetch address to instruction memory.
REQ-013 SHALL have port InstrD  output  INSTR_W  registered instruction to Decode.
REQ-014 SHALL have port PC_Plus1D  output  PC_W  registered PCF+1 to Decode.
REQ-015 SHALL have port ValidD  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-016 PC_Plus1F SHALL be PCF+1, modulo 2^PC_W: 127 -> 0 at PC_W=7, no carry out.
REQ-017 PCNextF SHALL be PCBranchD when PCSrcD=1, else PC_Plus1F.
REQ-018 PCBranchD SHALL be used as an unsigned address; no sign or width adjustment.
REQ-019 At each edge with StallF=0, PCF SHALL load PCNextF.
REQ-020 With StallF=1, PCF SHALL hold, regardless of PCSrcD (stall beats branch).
REQ-021 IF/ID SHALL load InstrF, PC_Plus1F and ValidD=1 at an edge with StallD=0 and FlushD=0.
REQ-022 With StallD=1, IF/ID SHALL hold all three fields, regardless of FlushD (stall beats flush).
REQ-023 With StallD=0 and FlushD=1, IF/ID SHALL load InstrD=0, PC_Plus1D=0, ValidD=0.
REQ-024 Fetch-to-Decode latency SHALL be exactly one cycle; no combinational path from any input to InstrD, PC_Plus1D or ValidD.
REQ-025 PCF SHALL be driven only by the PC register, with no combinational path from inputs.
REQ-026 The block SHALL NOT generate FlushD itself; the hazard unit drives it (normally FlushD = PCSrcD).
REQ-027 StallF=1 with StallD=0 SHALL be legal: IF/ID reloads the same PCF's instruction.

Reset
REQ-028 On rst=1, PCF SHALL become RESET_PC immediately, without waiting for a clock edge.
REQ-029 On rst=1, InstrD=0, PC_Plus1D=0 and ValidD=0 SHALL apply immediately.
REQ-030 Reset mid-operation SHALL discard any pending branch, stall or flush.
REQ-031 The first edge after rst deasserts SHALL behave as a normal edge per REQ-019..023.

Structure
REQ-032 PC_W, INSTR_W, RESET_PC defaults and the NOP encoding (all zeros) SHALL live in the shared CPU package.
REQ-033 The PC register SHALL be one sub-module, pc_register: async reset, enable = !StallF.
REQ-034 The IF/ID register SHALL be implemented inside fetch_stage.
REQ-035 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-036 Reset test: rst high mid-run with PCF=0x23 -> PCF=0, ValidD=0, InstrD=0 before the next edge; after release, PCF steps 0,1,2.
REQ-037 Wrap test: PCF=0x7E, no stall/branch -> PCF 0x7F then 0x00; PC_Plus1D follows one cycle later as 0x7F then 0x00.
REQ-038 Branch test: PCF=0x10, PCSrcD=1, FlushD=1, PCBranchD=0x05 -> next PCF=0x05, ValidD=0, InstrD=0; following cycle ValidD=1 with the instruction at 0x05.
REQ-039 Stall test: StallF=StallD=1 for 3 cycles at PCF=0x08 -> PCF, InstrD and PC_Plus1D constant; on release PCF=0x09.
REQ-040 Priority test: StallF=StallD=1 with PCSrcD=FlushD=1 and PCBranchD=0x40 -> PCF and IF/ID unchanged and ValidD unchanged.
REQ-041 Asymmetric stall test: StallF=1, StallD=0 at PCF=0x0C -> InstrD gets the instruction at 0x0C on consecutive cycles; PC_Plus1D=0x0D.
